// File: rtl/fifo_pkg.sv
// Shared definitions for the async FIFO family: occupancy encodings of the
// read-side prefetch buffer and the common data width default.
package fifo_pkg;

   // Default word width, shared with fifo_async_8X256.
   localparam int FIFO_DATA_WIDTH = 8;

   // Occupancy encodings of the 2-entry prefetch buffer.
   localparam logic [1:0] OCC_EMPTY = 2'd0;
   localparam logic [1:0] OCC_ONE   = 2'd1;
   localparam logic [1:0] OCC_TWO   = 2'd2;

endpackage

// File: rtl/fifo_skid_buf2.sv
// Two-entry in-order buffer: a head register that drives the stream plus a
// skid register that absorbs one extra word while the head is stalled.
module fifo_skid_buf2
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = FIFO_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] head_out,
   output logic [1:0]            occ_out
);

   logic [DATA_WIDTH-1:0] head_q, head_d;
   logic [DATA_WIDTH-1:0] skid_q, skid_d;
   logic [1:0]            occ_q, occ_d;

   // Next-state of the head/skid pair; a pop always removes the head and the
   // skid word (if any) moves forward, so order is preserved.
   always_comb begin
      head_d = head_q;
      skid_d = skid_q;
      occ_d  = occ_q;
      case (occ_q)
         OCC_EMPTY: begin
            if (push) begin
               head_d = push_data;
               occ_d  = OCC_ONE;
            end
         end
         OCC_ONE: begin
            if (push && pop) begin
               head_d = push_data;
            end else if (push) begin
               skid_d = push_data;
               occ_d  = OCC_TWO;
            end else if (pop) begin
               occ_d  = OCC_EMPTY;
            end
         end
         OCC_TWO: begin
            if (pop) begin
               head_d = skid_q;
               if (push) skid_d = push_data;
               else      occ_d  = OCC_ONE;
            end
         end
         default: occ_d = OCC_EMPTY;
      endcase
   end

   // State registers, cleared with the FIFO.
   always_ff @(posedge clk) begin
      if (rst) begin
         head_q <= '0;
         skid_q <= '0;
         occ_q  <= OCC_EMPTY;
      end else begin
         head_q <= head_d;
         skid_q <= skid_d;
         occ_q  <= occ_d;
      end
   end

   assign head_out = head_q;
   assign occ_out  = occ_q;

   // A word arriving into a full buffer with nothing leaving would be lost;
   // the credit logic upstream must make this unreachable.
   no_overflow: assert property (@(posedge clk) disable iff (rst)
      !(push && !pop && occ_q == OCC_TWO));

endmodule

// File: rtl/fifo_rd_stream_adapter.sv
// Read-side drain engine: pops the FIFO against Empty, absorbs its one-cycle
// registered read latency and presents words on a valid/ready stream.
// The word arriving from the FIFO is shown straight on the stream when the
// buffer is empty, so a word is visible the cycle after its pop and a
// continuous Ready_in sees one word per cycle.
module fifo_rd_stream_adapter
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  RClk,
   input  logic                  Clear_in,
   input  logic                  Empty_in,
   output logic                  ReadEn_out,
   input  logic [DATA_WIDTH-1:0] Data_in,
   output logic                  Valid_out,
   input  logic                  Ready_in,
   output logic [DATA_WIDTH-1:0] Data_out,
   output logic [CNT_WIDTH-1:0]  Word_Count_out
);

   logic                  inflight_q, inflight_d;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] head;
   logic [1:0]            occ;
   logic                  buf_valid, bypass, xfer_now, pop;
   logic                  buf_push, buf_pop;
   logic [2:0]            held;

   assign buf_valid = (occ != OCC_EMPTY);
   // Buffer empty but the FIFO word is on Data_in this cycle.
   assign bypass    = ~buf_valid & inflight_q;
   assign Valid_out = buf_valid | inflight_q;
   assign Data_out  = bypass ? Data_in : head;
   assign xfer_now  = Valid_out & Ready_in;

   // Words owed to the stream: buffered plus the one returning from the FIFO.
   assign held       = {1'b0, occ} + {2'b00, inflight_q};
   assign ReadEn_out = ~Clear_in & ~Empty_in & ((held < 3'd2) | xfer_now);
   assign pop        = ReadEn_out & ~Empty_in;

   // A bypassed word that is taken immediately never enters the buffer.
   assign buf_push = inflight_q & ~(bypass & Ready_in);
   assign buf_pop  = buf_valid & Ready_in;

   fifo_skid_buf2 #(.DATA_WIDTH(DATA_WIDTH)) u_buf (
      .clk       (RClk),
      .rst       (Clear_in),
      .push      (buf_push),
      .push_data (Data_in),
      .pop       (buf_pop),
      .head_out  (head),
      .occ_out   (occ)
   );

   // In-flight flag and wrapping transfer counter.
   always_comb begin
      inflight_d = pop;
      cnt_d      = cnt_q + {{(CNT_WIDTH-1){1'b0}}, xfer_now};
   end

   // Clear discards any in-flight word and the count.
   always_ff @(posedge RClk) begin
      if (Clear_in) begin
         inflight_q <= 1'b0;
         cnt_q      <= '0;
      end else begin
         inflight_q <= inflight_d;
         cnt_q      <= cnt_d;
      end
   end

   assign Word_Count_out = cnt_q;

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Self-checking bench: a queue-based FIFO read port drives two adapters
// (16-bit and 4-bit counters); a word-level scoreboard predicts every output.
module tb_fifo_rd_stream_adapter;

   logic       RClk = 1'b0;
   logic       Clear_in, Empty_in, Ready_in;
   logic [7:0] Data_in;
   logic       ReadEn_out, Valid_out;
   logic [7:0] Data_out;
   logic [15:0] Word_Count_out;
   logic       rd4, vld4;
   logic [7:0] dat4;
   logic [3:0] cnt4;

   fifo_rd_stream_adapter #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
      .RClk(RClk), .Clear_in(Clear_in), .Empty_in(Empty_in), .ReadEn_out(ReadEn_out),
      .Data_in(Data_in), .Valid_out(Valid_out), .Ready_in(Ready_in),
      .Data_out(Data_out), .Word_Count_out(Word_Count_out));

   fifo_rd_stream_adapter #(.DATA_WIDTH(8), .CNT_WIDTH(4)) dut4 (
      .RClk(RClk), .Clear_in(Clear_in), .Empty_in(Empty_in), .ReadEn_out(rd4),
      .Data_in(Data_in), .Valid_out(vld4), .Ready_in(Ready_in),
      .Data_out(dat4), .Word_Count_out(cnt4));

   always #5 RClk = ~RClk;

   int checks = 0, errors = 0, cyc = 0;
   logic [7:0]  fq[$];     // words still inside the FIFO
   logic [7:0]  pend[$];   // words popped in earlier cycles, not yet delivered
   logic [15:0] mcnt = '0;
   int ready_pct = 100, gap_pct = 0;
   bit force_ne = 1'b1, clr_next = 1'b1, last_p = 1'b0;
   int pops, xfers, first_rd, first_vld, first_x, last_x;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic clr_stats();
      pops = 0; xfers = 0; first_rd = -1; first_vld = -1; first_x = -1; last_x = -1;
   endtask

   // One clock: compare at the falling edge, then advance model and stimulus.
   task automatic tick();
      logic p, x, vexp, rexp;
      @(negedge RClk);
      vexp = (pend.size() > 0);
      rexp = !Clear_in && !Empty_in && (pend.size() < 2 || (vexp && Ready_in));
      chk("valid", Valid_out, vexp);
      chk("readen", ReadEn_out, rexp);
      if (vexp) chk("data", Data_out, pend[0]);
      chk("count", Word_Count_out, mcnt);
      chk("count4", cnt4, mcnt[3:0]);
      p = ReadEn_out && !Empty_in;
      x = Valid_out && Ready_in;
      if (ReadEn_out && first_rd < 0) first_rd = cyc;
      if (Valid_out && first_vld < 0) first_vld = cyc;
      if (x) begin
         if (first_x < 0) first_x = cyc;
         last_x = cyc;
         xfers++;
      end
      if (p) pops++;
      @(posedge RClk);
      #1;
      if (Clear_in) begin
         pend.delete();
         fq.delete();
         mcnt = '0;
         Data_in = 8'($urandom);
      end else begin
         if (x && pend.size() > 0) begin
            void'(pend.pop_front());
            mcnt++;
         end
         if (p && fq.size() > 0) begin
            Data_in = fq.pop_front();
            pend.push_back(Data_in);
         end else begin
            Data_in = 8'($urandom);   // stale read port content
         end
      end
      chk("held_le2", pend.size() <= 2, 1);
      last_p = p;
      cyc++;
      Clear_in = clr_next;
      Ready_in = ($urandom_range(99) < ready_pct);
      Empty_in = force_ne ? 1'b0 : (fq.size() == 0 || $urandom_range(99) < gap_pct);
   endtask

   task automatic drain(input int maxc);
      int n = 0;
      while ((fq.size() > 0 || pend.size() > 0) && n < maxc) begin
         tick();
         n++;
      end
      if (n >= maxc) begin
         checks++; errors++;
         $display("FAIL drain: got timeout after %0d cycles expected empty", n);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      Clear_in = 1'b1; Empty_in = 1'b0; Ready_in = 1'b0; Data_in = '0;
      clr_stats();
      @(posedge RClk); #1;

      // 1. Reset with a non-empty FIFO
      for (int i = 0; i < 3; i++) begin
         if (i == 2) begin clr_next = 1'b0; force_ne = 1'b0; end
         #2; chk("rst_readen", ReadEn_out, 0);
         tick();
      end
      #2;
      chk("rst_valid", Valid_out, 0);
      chk("rst_count", Word_Count_out, 0);
      chk("rst_data", Data_out, 0);

      // 2. Streaming 0x01..0x10
      clr_stats();
      ready_pct = 100;
      for (int i = 1; i <= 16; i++) fq.push_back(8'(i));
      drain(200);
      chk("latency", first_vld - first_rd, 1);
      chk("b2b_span", last_x - first_x, 15);
      chk("stream_xfers", xfers, 16);
      #2; chk("cnt16", Word_Count_out, 16);

      // 3. Backpressure
      clr_stats();
      ready_pct = 0;
      for (int i = 0; i < 8; i++) fq.push_back(8'hA0 + 8'(i));
      repeat (11) tick();
      chk("stall_pops_le2", pops <= 2, 1);
      #2;
      chk("stall_valid", Valid_out, 1);
      chk("stall_data", Data_out, 8'hA0);
      ready_pct = 100;
      drain(200);
      #2; chk("cnt24", Word_Count_out, 24);

      // 5. Reset with one word buffered and one in flight
      ready_pct = 0;
      for (int i = 0; i < 8; i++) fq.push_back(8'h30 + 8'(i));
      for (int n = 0; n < 20 && !(pend.size() == 2 && last_p); n++) tick();
      chk("mid_setup", pend.size(), 2);
      Clear_in = 1'b1; clr_next = 1'b0;
      tick();
      #2;
      chk("mid_valid", Valid_out, 0);
      chk("mid_count", Word_Count_out, 0);
      ready_pct = 100;
      for (int i = 0; i < 4; i++) fq.push_back(8'h50 + 8'(i));
      drain(100);
      #2; chk("mid_after", Word_Count_out, 4);

      // 6. Counter wrap on the 4-bit instance
      Clear_in = 1'b1; clr_next = 1'b0;
      tick();
      for (int i = 0; i < 17; i++) fq.push_back(8'h60 + 8'(i));
      drain(200);
      #2;
      chk("wrap4", cnt4, 1);
      chk("cnt17", Word_Count_out, 17);

      // 4. Random Ready_in and Empty gaps, 1000 words
      clr_stats();
      ready_pct = 50; gap_pct = 30;
      for (int i = 0; i < 1000; i++) fq.push_back(8'($urandom));
      drain(20000);
      chk("rand_xfers", xfers, 1000);
      #2; chk("cnt1017", Word_Count_out, 1017);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
